// File: rtl/int_ctrl_if.sv
// int_ctrl_if: bus between the interrupt sequencer and the core / CP0 side
interface int_ctrl_if #(
  parameter int N_IRQ = 3
) ();
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             insn_boundary;
  logic [31:0]      pc_resume;
  logic             eret;
  logic [31:0]      epc_in;
  logic             epc_we;
  logic [31:0]      epc_din;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic [N_IRQ-1:0] serving;
  logic [N_IRQ-1:0] pending;
  logic             in_handler;
  modport master (
    output irq_in, irq_mask, insn_boundary, pc_resume, eret, epc_in,
    input  epc_we, epc_din, redirect, redirect_pc, flush, serving, pending, in_handler
  );
  modport slave (
    input  irq_in, irq_mask, insn_boundary, pc_resume, eret, epc_in,
    output epc_we, epc_din, redirect, redirect_pc, flush, serving, pending, in_handler
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: single-level interrupt sequencer (EPC save, vector redirect, ERET return)
module int_ctrl #(
  parameter int          N_IRQ        = 3,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0800,
  parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
  input logic       clk,
  input logic       clr,
  int_ctrl_if.slave bus
);
  localparam int IW = N_IRQ > 1 ? $clog2(N_IRQ) : 1;
  typedef enum logic [2:0] {S_IDLE, S_SAVE, S_VECTOR, S_HANDLER, S_RETURN} state_t;
  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_q, pending_q, pending_d, serving_q, serving_d, elig, sel_oh;
  logic [IW-1:0]    sel_q, sel_d, sel_idx;
  logic [31:0]      pc_lat_q, pc_lat_d;
  assign elig   = pending_q & ~bus.irq_mask;
  assign sel_oh = N_IRQ'(1) << sel_q;
  always_comb begin
    sel_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (elig[i]) sel_idx = IW'(i);
  end
  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    pc_lat_d        = pc_lat_q;
    serving_d       = serving_q;
    pending_d       = (pending_q & ~(state_q == S_SAVE ? sel_oh : '0)) | (bus.irq_in & ~irq_q);
    bus.epc_we      = 1'b0;
    bus.epc_din     = '0;
    bus.redirect    = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_pc = '0;
    case (state_q)
      S_IDLE: if (|elig && bus.insn_boundary) begin
        state_d  = S_SAVE;
        sel_d    = sel_idx;
        pc_lat_d = bus.pc_resume;
      end
      S_SAVE: begin
        bus.epc_we  = 1'b1;
        bus.epc_din = pc_lat_q;
        serving_d   = sel_oh;
        state_d     = S_VECTOR;
      end
      S_VECTOR: begin
        bus.redirect    = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect_pc = HANDLER_BASE + 32'(sel_q) * VEC_STRIDE;
        state_d         = S_HANDLER;
      end
      S_HANDLER: state_d = bus.eret ? S_RETURN : S_HANDLER;
      S_RETURN: begin
        bus.redirect    = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect_pc = bus.epc_in;
        serving_d       = '0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.serving    = serving_q;
  assign bus.pending    = pending_q;
  assign bus.in_handler = state_q inside {S_VECTOR, S_HANDLER, S_RETURN};
  // irq_q tracks the lines even in reset so a line already high at release is not a new request
  always_ff @(posedge clk) begin
    irq_q <= bus.irq_in;
    if (clr) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      serving_q <= '0;
      sel_q     <= '0;
      pc_lat_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      serving_q <= serving_d;
      sel_q     <= sel_d;
      pc_lat_q  <= pc_lat_d;
    end
  end
endmodule
